// File: rtl/io_pkg.sv
// Shared widths, tag constants and the IN-result extend rule for the I/O unit.
package io_pkg;
  localparam int IO_XLEN     = 32;
  localparam int IO_TAG_W    = 6;
  localparam int IO_DATA_W   = 8;
  localparam int IO_TAG_NONE = 0;

  typedef enum logic {IO_OP_OUT = 1'b0, IO_OP_IN = 1'b1} io_op_e;

  // Widen a dw-bit byte (already zero-padded in raw) to IO_XLEN bits.
  function automatic logic [IO_XLEN-1:0] io_extend(input logic [IO_XLEN-1:0] raw,
                                                   input int unsigned dw, input bit sx);
    logic [IO_XLEN-1:0] m_hi;
    logic               neg;
    m_hi = '1;
    m_hi = m_hi << dw;
    neg  = sx && ((raw & (IO_XLEN'(1) << (dw - 1))) != '0);
    return neg ? (raw | m_hi) : (raw & ~m_hi);
  endfunction
endpackage

// File: rtl/io_fifo_unit_if.sv
// Issue/writeback/serial handshake bundle for io_fifo_unit.
interface io_fifo_unit_if #(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 6,
  parameter int DATA_W    = 8,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
);
  logic                          op_vld;
  logic                          op_is_in;
  logic [TAG_W-1:0]              op_dd;
  logic [XLEN-1:0]               op_ds_val;
  logic                          op_rdy;
  logic                          flush;
  logic [TAG_W-1:0]              wb_addr;
  logic [XLEN-1:0]               wb_val;
  logic [$clog2(IN_DEPTH):0]     rx_count;
  logic [$clog2(OUT_DEPTH):0]    tx_count;
  logic [DATA_W-1:0]             io_in_data;
  logic                          io_in_vld;
  logic                          io_in_rdy;
  logic [DATA_W-1:0]             io_out_data;
  logic                          io_out_vld;
  logic                          io_out_rdy;

  modport slave (
    input  op_vld, op_is_in, op_dd, op_ds_val, flush, io_in_data, io_in_vld, io_out_rdy,
    output op_rdy, wb_addr, wb_val, rx_count, tx_count, io_in_rdy, io_out_data, io_out_vld
  );
  modport master (
    output op_vld, op_is_in, op_dd, op_ds_val, flush, io_in_data, io_in_vld, io_out_rdy,
    input  op_rdy, wb_addr, wb_val, rx_count, tx_count, io_in_rdy, io_out_data, io_out_vld
  );
endinterface

// File: rtl/io_sync_fifo.sv
// Small synchronous FIFO; push and pop may both happen in one cycle at any count.
// The caller guarantees no push when full and no pop when empty.
module io_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [W-1:0]             i_push_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;

  // Pointers wrap naturally (DEPTH is a power of two); clear drops everything.
  always_ff @(posedge clk) begin
    if (!rstn || i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset: stale entries are never visible because head is masked when empty.
  always_ff @(posedge clk) begin
    if (rstn && !i_clear && i_push) r_mem[r_wptr] <= i_push_data;
  end

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_head  = o_empty ? '0 : r_mem[r_rptr];
endmodule

// File: rtl/io_fifo_unit.sv
// Buffered IN/OUT unit: OUT ops queue bytes to the transmitter, IN ops pop bytes
// prefetched from the receiver and write them back one cycle later.
module io_fifo_unit
  import io_pkg::*;
#(
  parameter int XLEN        = IO_XLEN,
  parameter int TAG_W       = IO_TAG_W,
  parameter int DATA_W      = IO_DATA_W,
  parameter int IN_DEPTH    = 4,
  parameter int OUT_DEPTH   = 4,
  parameter int SIGN_EXT_IN = 0
) (
  input  logic          clk,
  input  logic          rstn,
  io_fifo_unit_if.slave bus
);
  io_op_e            w_op;
  logic              w_acc, w_in_pop, w_tx_push, w_tx_pop, w_rx_push;
  logic              w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
  logic [DATA_W-1:0] w_rx_head, w_tx_head;
  logic [TAG_W-1:0]  r_wb_addr;
  logic [XLEN-1:0]   r_wb_val;

  assign w_op = bus.op_is_in ? IO_OP_IN : IO_OP_OUT;

  // Ready looks only at start-of-cycle occupancy, so no same-cycle bypass exists.
  assign bus.op_rdy = !bus.flush && ((w_op == IO_OP_IN) ? !w_rx_empty : !w_tx_full);
  assign w_acc      = bus.op_vld && bus.op_rdy;
  assign w_in_pop   = w_acc && (w_op == IO_OP_IN);
  assign w_tx_push  = w_acc && (w_op == IO_OP_OUT);

  assign bus.io_in_rdy   = !w_rx_full && !bus.flush;
  assign w_rx_push       = bus.io_in_vld && bus.io_in_rdy;
  assign bus.io_out_vld  = !w_tx_empty;
  assign bus.io_out_data = w_tx_head;
  assign w_tx_pop        = bus.io_out_vld && bus.io_out_rdy && !bus.flush;

  io_sync_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_rx (
    .clk, .rstn, .i_clear(bus.flush),
    .i_push(w_rx_push), .i_push_data(bus.io_in_data), .i_pop(w_in_pop),
    .o_head(w_rx_head), .o_count(bus.rx_count), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  io_sync_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_tx (
    .clk, .rstn, .i_clear(bus.flush),
    .i_push(w_tx_push), .i_push_data(bus.op_ds_val[DATA_W-1:0]), .i_pop(w_tx_pop),
    .o_head(w_tx_head), .o_count(bus.tx_count), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  // Writeback: tag pulses for one cycle after an accepted IN; value holds otherwise.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wb_addr <= TAG_W'(IO_TAG_NONE);
      r_wb_val  <= '0;
    end else if (w_in_pop) begin
      r_wb_addr <= bus.op_dd;
      r_wb_val  <= XLEN'(io_extend(IO_XLEN'(w_rx_head), DATA_W, SIGN_EXT_IN != 0));
    end else begin
      r_wb_addr <= TAG_W'(IO_TAG_NONE);
    end
  end

  assign bus.wb_addr = r_wb_addr;
  assign bus.wb_val  = r_wb_val;

  // Only the low byte of the source operand is transmitted.
  generate
    if (XLEN > DATA_W) begin : g_hi
      logic w_unused_hi;
      assign w_unused_hi = ^bus.op_ds_val[XLEN-1:DATA_W];
    end
  endgenerate
endmodule

// File: tb/tb_io_fifo_unit.sv
// Scoreboard bench: a model updated at issue time queues expected bytes/writebacks,
// and a negedge monitor compares every DUT output against it. Two DUTs share the
// stimulus, one zero-extending and one sign-extending IN results.
module tb_io_fifo_unit;
  logic        clk = 0;
  logic        rstn = 0;
  logic        op_vld = 0, op_is_in = 0, flush = 0, in_vld = 0, out_rdy = 0;
  logic [5:0]  op_dd = 0;
  logic [31:0] op_ds_val = 0;
  logic [7:0]  in_data = 0;
  bit          armed = 0;
  int          n_pass = 0, n_tot = 0;

  typedef struct { logic [5:0] a; logic [31:0] v; } wb_t;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  wb_t        wbq0[$];
  wb_t        wbq1[$];

  always #5 clk = ~clk;

  io_fifo_unit_if #(.XLEN(32), .TAG_W(6), .DATA_W(8), .IN_DEPTH(4), .OUT_DEPTH(4)) b0();
  io_fifo_unit_if #(.XLEN(32), .TAG_W(6), .DATA_W(8), .IN_DEPTH(4), .OUT_DEPTH(4)) b1();

  io_fifo_unit #(.SIGN_EXT_IN(0)) u0 (.clk(clk), .rstn(rstn), .bus(b0));
  io_fifo_unit #(.SIGN_EXT_IN(1)) u1 (.clk(clk), .rstn(rstn), .bus(b1));

  assign b0.op_vld = op_vld;   assign b1.op_vld = op_vld;
  assign b0.op_is_in = op_is_in; assign b1.op_is_in = op_is_in;
  assign b0.op_dd = op_dd;     assign b1.op_dd = op_dd;
  assign b0.op_ds_val = op_ds_val; assign b1.op_ds_val = op_ds_val;
  assign b0.flush = flush;     assign b1.flush = flush;
  assign b0.io_in_data = in_data; assign b1.io_in_data = in_data;
  assign b0.io_in_vld = in_vld; assign b1.io_in_vld = in_vld;
  assign b0.io_out_rdy = out_rdy; assign b1.io_out_rdy = out_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Monitor + model: compare current outputs, then apply this cycle's transfers.
  always @(negedge clk) begin
    if (armed) begin
      wb_t e;
      logic [7:0] b;
      chk("rx_count", 32'(b0.rx_count), rxq.size());
      chk("tx_count", 32'(b0.tx_count), txq.size());
      chk("rx_count_max", 32'(b0.rx_count <= 4), 1);
      chk("io_out_vld", 32'(b0.io_out_vld), 32'(txq.size() != 0));
      chk("io_out_data", 32'(b0.io_out_data), (txq.size() != 0) ? 32'(txq[0]) : 0);
      chk("io_in_rdy", 32'(b0.io_in_rdy), 32'(rxq.size() != 4 && !flush));
      if (op_vld)
        chk("op_rdy", 32'(b0.op_rdy),
            32'(!flush && (op_is_in ? (rxq.size() != 0) : (txq.size() != 4))));
      if (wbq0.size() != 0) begin
        e = wbq0.pop_front();
        chk("wb_addr", 32'(b0.wb_addr), 32'(e.a));
        chk("wb_val_zx", b0.wb_val, e.v);
        e = wbq1.pop_front();
        chk("wb_val_sx", b1.wb_val, e.v);
      end else begin
        chk("wb_addr_idle", 32'(b0.wb_addr), 0);
        chk("wb_addr_idle_sx", 32'(b1.wb_addr), 0);
      end
      if (!rstn || flush) begin
        rxq.delete(); txq.delete();
      end else begin
        if (b0.io_out_vld && out_rdy && txq.size() != 0) void'(txq.pop_front());
        if (op_vld && op_is_in && b0.op_rdy) begin
          if (rxq.size() == 0) chk("in_pop_empty", 1, 0);
          else begin
            b = rxq.pop_front();
            if (op_dd != 0) begin
              wbq0.push_back('{op_dd, {24'h0, b}});
              wbq1.push_back('{op_dd, {{24{b[7]}}, b}});
            end
          end
        end
        if (in_vld && b0.io_in_rdy) rxq.push_back(in_data);
        if (op_vld && !op_is_in && b0.op_rdy) txq.push_back(op_ds_val[7:0]);
      end
    end
  end

  initial begin
    // Reset and idle
    step(); step();
    rstn = 1; armed = 1;
    step();
    chk("reset_in_rdy", 32'(b0.io_in_rdy), 1);
    chk("reset_out_vld", 32'(b0.io_out_vld), 0);
    op_vld = 1; op_is_in = 1; op_dd = 3;
    #1 chk("op_rdy_in_empty", 32'(b0.op_rdy), 0);
    step(); op_vld = 0;

    // Fill transmit FIFO with a stalled transmitter, then drain in order
    out_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      op_vld = 1; op_is_in = 0; op_ds_val = 32'h41 + i; step();
    end
    chk("tx_full_count", 32'(b0.tx_count), 4);
    op_ds_val = 32'h45;
    #1 chk("op_rdy_tx_full", 32'(b0.op_rdy), 0);
    step(); op_vld = 0; out_rdy = 1;
    for (int i = 0; i < 5; i++) step();
    out_rdy = 0;

    // One IN of 0x80: zero- vs sign-extended writeback
    in_vld = 1; in_data = 8'h80; step(); in_vld = 0;
    op_vld = 1; op_is_in = 1; op_dd = 5; step(); op_vld = 0;
    chk("wb_addr_5", 32'(b0.wb_addr), 5);
    chk("wb_val_80_zx", b0.wb_val, 32'h0000_0080);
    chk("wb_val_80_sx", b1.wb_val, 32'hFFFF_FF80);

    // Receive FIFO full, byte held while an IN pops in the same cycle
    for (int i = 0; i < 4; i++) begin
      in_vld = 1; in_data = 8'h10 + 8'(i); step();
    end
    chk("rx_full_count", 32'(b0.rx_count), 4);
    in_data = 8'h14; op_vld = 1; op_is_in = 1; op_dd = 7;
    step(); op_vld = 0;
    chk("rx_after_pop", 32'(b0.rx_count), 3);
    chk("in_rdy_after_pop", 32'(b0.io_in_rdy), 1);
    step(); in_vld = 0;
    for (int i = 0; i < 4; i++) begin
      op_vld = 1; op_is_in = 1; op_dd = 6'(8 + i); step();
    end
    op_vld = 0; step();

    // Wrap: 10 bytes through each FIFO with random stalls
    begin
      int o_sent = 0, i_sent = 0, i_done = 0, cyc = 0;
      while ((o_sent < 10 || i_done < 10 || b0.tx_count != 0) && cyc < 400) begin
        out_rdy = 1'($urandom_range(0, 1));
        in_vld  = (i_sent < 10) && 1'($urandom_range(0, 1));
        in_data = 8'hC0 + 8'(i_sent);
        op_vld  = 0;
        if (o_sent < 10 && $urandom_range(0, 1) == 1) begin
          op_vld = 1; op_is_in = 0; op_ds_val = 32'hDEAD_BE00 | (32'hA0 + 32'(o_sent));
        end else if (i_done < 10) begin
          op_vld = 1; op_is_in = 1; op_dd = 6'd12;
        end
        #1;
        if (op_vld && b0.op_rdy) begin
          if (op_is_in) i_done++; else o_sent++;
        end
        if (in_vld && b0.io_in_rdy) i_sent++;
        step(); cyc++;
      end
      op_vld = 0; in_vld = 0; out_rdy = 0;
      chk("wrap_done", 32'(cyc < 400), 1);
    end
    step();

    // flush with tx=3, rx=2 and traffic presented in the flush cycle
    for (int i = 0; i < 3; i++) begin
      op_vld = 1; op_is_in = 0; op_ds_val = 32'h51 + i;
      in_vld = (i < 2); in_data = 8'h61 + 8'(i); step();
    end
    op_vld = 0; in_vld = 0;
    chk("pre_flush_tx", 32'(b0.tx_count), 3);
    chk("pre_flush_rx", 32'(b0.rx_count), 2);
    flush = 1; op_vld = 1; op_is_in = 1; op_dd = 9; in_vld = 1; out_rdy = 1;
    step();
    flush = 0; op_vld = 0; in_vld = 0; out_rdy = 0;
    chk("flush_tx", 32'(b0.tx_count), 0);
    chk("flush_rx", 32'(b0.rx_count), 0);
    chk("flush_out_vld", 32'(b0.io_out_vld), 0);
    chk("flush_wb_addr", 32'(b0.wb_addr), 0);

    // Reset in the middle of a burst
    for (int i = 0; i < 3; i++) begin
      op_vld = 1; op_is_in = 0; op_ds_val = 32'h71 + i;
      in_vld = (i < 2); in_data = 8'h81 + 8'(i); step();
    end
    op_vld = 0; in_vld = 0;
    rstn = 0; step(); rstn = 1;
    chk("rst_tx", 32'(b0.tx_count), 0);
    chk("rst_rx", 32'(b0.rx_count), 0);
    chk("rst_out_vld", 32'(b0.io_out_vld), 0);
    chk("rst_out_data", 32'(b0.io_out_data), 0);
    chk("rst_wb_val", b0.wb_val, 0);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/io_fifo_unit.md
Name: io_fifo_unit

Overview:
Buffered successor to the blocking single-byte IN/OUT path in the execution unit. OUT ops push bytes into a transmit FIFO and retire immediately. The receive FIFO prefetches bytes from the serial receiver, so IN ops normally complete in one cycle. Sits beside the ALU/MEM pipes; its result is muxed onto the writeback bus the same way ALU/MEM results are.

Parameters:
XLEN, 32, register/operand width
TAG_W, 6, destination register tag width; tag 0 means no writeback
DATA_W, 8, I/O byte width; must be <= XLEN
IN_DEPTH, 4, receive FIFO entries; power of two, >= 2
OUT_DEPTH, 4, transmit FIFO entries; power of two, >= 2
SIGN_EXT_IN, 0, 1 = IN result sign-extended, 0 = zero-extended

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
op_vld  in  1  IN/OUT op presented by issue
op_is_in  in  1  1 = IN, 0 = OUT
op_dd  in  TAG_W  destination tag (IN only)
op_ds_val  in  XLEN  source operand; OUT sends bits [DATA_W-1:0]
op_rdy  out  1  op accepted this cycle when op_vld && op_rdy (combinational)
flush  in  1  synchronous clear of both FIFOs
wb_addr  out  TAG_W  writeback tag; 0 = none
wb_val  out  XLEN  writeback value
rx_count  out  $clog2(IN_DEPTH)+1  receive FIFO occupancy
tx_count  out  $clog2(OUT_DEPTH)+1  transmit FIFO occupancy
io_in_data  in  DATA_W  receiver byte
io_in_vld  in  1  receiver byte valid
io_in_rdy  out  1  unit can take a byte
io_out_data  out  DATA_W  transmit byte
io_out_vld  out  1  transmit byte valid
io_out_rdy  in  1  transmitter accepts byte

Behaviour:
- Reset (rstn low at a clk edge): both FIFOs emptied; pointers and counts 0; wb_addr=0, wb_val=0. Next cycle: io_in_rdy=1, io_out_vld=0, io_out_data=0, rx_count=tx_count=0. Reset mid-transfer drops all buffered bytes; no partial state survives.
- op_rdy = op_is_in ? (rx_count != 0) : (tx_count != OUT_DEPTH). It depends only on occupancy at the start of the cycle. A same-cycle pop does not free space for a same-cycle push, and there is no bypass from io_in to IN.
- Handshakes are valid/ready. A transfer occurs on a cycle where both are high. vld must not depend on rdy.
- io_in_rdy = (rx_count != IN_DEPTH) && !flush. On transfer, io_in_data is written at the receive write pointer.
- io_out_vld = (tx_count != 0). io_out_data = transmit head entry, driven from registers. Head holds stable while vld && !rdy. Empty FIFO drives io_out_data = 0.
- Accepted OUT: push op_ds_val[DATA_W-1:0]. No writeback; wb_addr=0 next cycle.
- Accepted IN: pop the receive head. Next cycle: wb_addr=op_dd, wb_val=head extended to XLEN per SIGN_EXT_IN. An IN with op_dd=0 still pops; the byte is discarded.
- Cycles with no accepted IN: wb_addr=0 next cycle. wb_val holds its previous value.
- Push and pop on the same FIFO in one cycle: both occur, count unchanged, pointers advance. This is legal at any count; push-while-full is already blocked by rdy.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Counts are one bit wider and range 0..DEPTH.
- flush: next cycle both FIFOs are empty. Any push/pop in the flush cycle is discarded, and op_rdy is forced 0. wb_addr=0 next cycle.
- Ordering: bytes leave io_out in OUT-issue order. IN ops return bytes in io_in arrival order.

Decomposition:
- Shared package io_pkg: IO_TAG_NONE=0, default widths (XLEN, TAG_W, DATA_W), and a function for the extend rule.
- One sub-module, io_sync_fifo, instantiated twice (rx, tx).
  - Parameters: W, DEPTH.
  - Ports: push, push_data, pop, head, count, full, empty, clear.
  - Same-cycle push/pop semantics as above.

Test Plan:
- Reset, then idle → io_in_rdy=1, io_out_vld=0, rx_count=0, tx_count=0, wb_addr=0; IN op presented → op_rdy=0.
- Four OUTs of 0x41..0x44 with io_out_rdy=0 → tx_count=4, fifth OUT sees op_rdy=0; raise rdy → bytes 41,42,43,44 appear in order, one per cycle.
- Receiver sends 0x80, then IN dd=5 with SIGN_EXT_IN=0 → next cycle wb_addr=5, wb_val=0x00000080; repeat with SIGN_EXT_IN=1 → 0xFFFFFF80.
- rx FIFO full (4 bytes), io_in_vld held high, IN op same cycle → pop happens, no push that cycle, io_in_rdy=1 next cycle, 5th byte accepted next cycle, order preserved.
- Wrap: push/pop 10 bytes through each FIFO with random stalls → counts never exceed 4, data order intact across pointer wrap.
- flush with tx_count=3, rx_count=2 → both 0 next cycle, io_out_vld=0, wb_addr=0; rstn low mid-burst → same result.
